demux1_4: RTL and testbench
===========================

# demux1_4

Registered 1-to-4 word distributor: the fan-out counterpart of the registered 4-to-1 select mux in the processor datapath. A 32-bit word arriving on a single input with a 2-bit lane select is buffered into one of four independent per-lane FIFOs. Each lane presents its head word to its consumer under a valid/ready handshake. It sits where one pipeline producer (e.g. the writeback/forwarding bus) must feed four independent consumers that can stall individually.

## Interface
- DEPTH, 2, entries per lane FIFO; power of two, ≥2
- WIDTH, 32, data width
- c  in  1  clock; all state updates on posedge c
- rst  in  1  reset, synchronous, active-high
- i  in  WIDTH  input word
- iv  in  1  input valid
- s  in  2  lane select for i (0..3)
- irdy  out  1  input ready
- out0..out3  out  WIDTH  head word of lane N; forced to 0 when vN=0
- v0..v3  out  1  lane N non-empty
- rdy0..rdy3  in  1  consumer N ready

## Operation
- Each lane: DEPTH-entry circular buffer, write pointer wp, read pointer rp (log2(DEPTH) bits, wrap modulo DEPTH), occupancy count cnt (log2(DEPTH)+1 bits, 0..DEPTH).
- irdy = (cnt[s] != DEPTH). Depends only on s and registered state; no combinational path from any rdyN to irdy.
- Push: iv & irdy at posedge c → i written at lane s, wp[s]++, cnt[s]++.
- Pop lane N: vN & rdyN at posedge c → rp[N]++, cnt[N]--.
- Same-lane push and pop in one cycle: both performed, cnt unchanged. Legal only when irdy=1 (lane not full); a full lane does not accept a push even if popped that cycle.
- Pops on all four lanes and one push may occur in the same cycle; lanes are fully independent.
- vN = (cnt[N] != 0); outN = buf[N][rp[N]] when vN, else 0.
- iv=0: i and s ignored, no state change. iv=1 with irdy=0: word not accepted; producer holds i/s/iv until accepted (producer rule; block does not latch).
- Word order within a lane is strictly FIFO; no ordering between lanes.
- rdyN while vN=0: no effect.

## Timing
- Reset (rst=1 at posedge c): all cnt, wp, rp ← 0; buffer contents don't-care. Next cycle: v0..v3=0, out0..out3=0, irdy=1. Reset overrides any push/pop in the same cycle; in-flight words discarded.
- Latency: word accepted at edge k is on outN with vN=1 after edge k (visible cycle k+1) if lane was empty; otherwise behind its predecessors.
- Throughput: one push per cycle; one pop per lane per cycle; a lane sustains 1 word/cycle with simultaneous push/pop.
- Full: after DEPTH pushes with no pops, irdy=0 whenever s selects that lane; irdy=1 for s selecting a non-full lane.
- Pointer wrap: rp/wp roll from DEPTH-1 to 0 with no bubble.

## Test plan
- Reset: assert rst 2 cycles with iv=1, s=2, i=0xDEADBEEF → after release v0..v3=0, out0..out3=0, irdy=1; no word appears on lane 2.
- Single route: i=0x12345678, s=1, iv=1 for one cycle → next cycle v1=1, out1=0x12345678, v0=v2=v3=0; rdy1=1 one cycle → v1=0, out1=0.
- Fill/full: rdy0=0, push 0xA0,0xA1 to s=0 → irdy=0 while s=0, irdy=1 when s=3; third push 0xA2 held 3 cycles not accepted; then rdy0=1 → out0 sequence 0xA0,0xA1,0xA2 on consecutive cycles.
- Simultaneous push/pop, lane 3 holding 1 word: push 0xB1 while popping 0xB0 → cnt stays 1, next out3=0xB1; continue 10 cycles streaming 0xB2..0xBB with rdy3=1 → one word per cycle, in order, across pointer wrap.
- Independence: push 0xC0..0xC3 to s=0,1,2,3 in 4 cycles with all rdyN=0 → all vN=1, outN=0xCN; release rdy2 only → only lane 2 drains.
- Reset mid-operation: lanes 0 and 2 holding words, rst=1 for one cycle with a same-cycle push → all vN=0, irdy=1 next cycle, no stale word ever reappears.

Source files
------------

// File: rtl/demux1_4.sv
// demux1_4: registered 1-to-4 word distributor.
//
// One producer word (i, tagged with lane select s) is buffered into one of four
// independent per-lane circular FIFOs. Each lane presents its head word under a
// valid/ready handshake so the four consumers can stall independently.
//
// Ports:
//   c            clock, all state updates on posedge
//   rst          synchronous active-high reset (clears pointers and counts)
//   i, iv, s     input word, input valid, lane select (0..3)
//   irdy         input ready: selected lane is not full
//   out0..out3   head word of lane N, forced to 0 while vN=0
//   v0..v3       lane N non-empty
//   rdy0..rdy3   consumer N ready
module demux1_4 #(
    parameter int unsigned DEPTH = 2,  // entries per lane, power of two, >= 2
    parameter int unsigned WIDTH = 32
) (
    input  logic             c,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic             iv,
    input  logic [1:0]       s,
    output logic             irdy,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             v0,
    output logic             v1,
    output logic             v2,
    output logic             v3,
    input  logic             rdy0,
    input  logic             rdy1,
    input  logic             rdy2,
    input  logic             rdy3
);

    localparam int          NLANES = 4;
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW     = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Storage has no reset: contents are don't-care once counts are cleared.
    logic [WIDTH-1:0] mem_q [NLANES][DEPTH];

    logic [AW-1:0] wp_q  [NLANES];
    logic [AW-1:0] wp_d  [NLANES];
    logic [AW-1:0] rp_q  [NLANES];
    logic [AW-1:0] rp_d  [NLANES];
    logic [CW-1:0] cnt_q [NLANES];
    logic [CW-1:0] cnt_d [NLANES];

    logic [NLANES-1:0] rdy;
    logic [NLANES-1:0] vld;
    logic [NLANES-1:0] push;
    logic [NLANES-1:0] pop;
    logic [WIDTH-1:0]  head [NLANES];

    assign rdy = {rdy3, rdy2, rdy1, rdy0};

    // irdy looks only at the selected lane's registered count, so a full lane
    // refuses a push even if it is being popped in the same cycle. This keeps
    // consumer ready signals off the producer's combinational path.
    always_comb begin
        irdy = (cnt_q[s] != FULL);
        push = '0;
        if (iv && irdy) begin
            push = NLANES'(1) << s;
        end
    end

    always_comb begin
        for (int l = 0; l < NLANES; l++) begin
            vld[l]  = (cnt_q[l] != '0);
            pop[l]  = vld[l] & rdy[l];
            head[l] = vld[l] ? mem_q[l][rp_q[l]] : '0;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_comb begin
        for (int l = 0; l < NLANES; l++) begin
            wp_d[l]  = wp_q[l] + AW'(push[l]);
            rp_d[l]  = rp_q[l] + AW'(pop[l]);
            cnt_d[l] = cnt_q[l];
            unique case ({push[l], pop[l]})
                2'b10:   cnt_d[l] = cnt_q[l] + CW'(1);
                2'b01:   cnt_d[l] = cnt_q[l] - CW'(1);
                default: cnt_d[l] = cnt_q[l];
            endcase
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            for (int l = 0; l < NLANES; l++) begin
                wp_q[l]  <= '0;
                rp_q[l]  <= '0;
                cnt_q[l] <= '0;
            end
        end else begin
            for (int l = 0; l < NLANES; l++) begin
                wp_q[l]  <= wp_d[l];
                rp_q[l]  <= rp_d[l];
                cnt_q[l] <= cnt_d[l];
            end
        end
    end

    always_ff @(posedge c) begin
        for (int l = 0; l < NLANES; l++) begin
            if (push[l] && !rst) begin
                mem_q[l][wp_q[l]] <= i;
            end
        end
    end

    assign out0 = head[0];
    assign out1 = head[1];
    assign out2 = head[2];
    assign out3 = head[3];
    assign v0   = vld[0];
    assign v1   = vld[1];
    assign v2   = vld[2];
    assign v3   = vld[3];

endmodule

// File: tb/tb_demux1_4.sv
// Testbench for demux1_4: directed scenarios followed by constrained-random
// traffic. A reference model keeps per-lane expected-word queues; a monitor on
// the falling edge compares every presented lane output against them.
module tb_demux1_4;

    localparam int DEPTH = 2;
    localparam int WIDTH = 32;

    logic             c = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] i;
    logic             iv;
    logic [1:0]       s;
    logic             irdy;
    logic [WIDTH-1:0] out0, out1, out2, out3;
    logic             v0, v1, v2, v3;
    logic [3:0]       rdy;

    demux1_4 #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .c    (c),
        .rst  (rst),
        .i    (i),
        .iv   (iv),
        .s    (s),
        .irdy (irdy),
        .out0 (out0),
        .out1 (out1),
        .out2 (out2),
        .out3 (out3),
        .v0   (v0),
        .v1   (v1),
        .v2   (v2),
        .v3   (v3),
        .rdy0 (rdy[0]),
        .rdy1 (rdy[1]),
        .rdy2 (rdy[2]),
        .rdy3 (rdy[3])
    );

    always #5 c = ~c;

    int errors = 0;
    int checks = 0;

    // Reference model: occupancy and expected words per lane.
    int               mcnt [4];
    logic [WIDTH-1:0] expq [4][$];
    bit               acc;
    bit               last_acc = 1'b0;

    always @(posedge c) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                mcnt[n] = 0;
                expq[n].delete();
            end
            last_acc = 1'b0;
        end else begin
            acc = iv && (mcnt[s] != DEPTH);
            for (int n = 0; n < 4; n++) begin
                if (mcnt[n] != 0 && rdy[n]) mcnt[n]--;
            end
            if (acc) begin
                mcnt[s]++;
                expq[s].push_back(i);
            end
            last_acc = acc;
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] get_out(input int n);
        case (n)
            0:       return out0;
            1:       return out1;
            2:       return out2;
            default: return out3;
        endcase
    endfunction

    function automatic logic get_v(input int n);
        case (n)
            0:       return v0;
            1:       return v1;
            2:       return v2;
            default: return v3;
        endcase
    endfunction

    // Monitor: pops the expected word on each handshake, peeks otherwise.
    always @(negedge c) begin
        if (!rst) begin
            check("irdy", {31'b0, irdy}, {31'b0, (mcnt[s] != DEPTH)});
            for (int n = 0; n < 4; n++) begin
                logic             vn;
                logic [WIDTH-1:0] o;
                logic [WIDTH-1:0] e;
                vn = get_v(n);
                o  = get_out(n);
                check($sformatf("v%0d", n), {31'b0, vn}, {31'b0, (mcnt[n] != 0)});
                if (vn) begin
                    if (expq[n].size() == 0) begin
                        check($sformatf("out%0d_unexpected", n), o, 'x);
                    end else begin
                        e = rdy[n] ? expq[n].pop_front() : expq[n][0];
                        check($sformatf("out%0d", n), o, e);
                    end
                end else begin
                    check($sformatf("out%0d_idle", n), o, '0);
                end
            end
        end
    end

    task automatic cyc(input logic iv_, input logic [1:0] s_, input logic [WIDTH-1:0] i_,
                       input logic [3:0] rdy_);
        iv  = iv_;
        s   = s_;
        i   = i_;
        rdy = rdy_;
        @(posedge c);
        #1;
    endtask

    initial begin
        // Reset held two cycles with a push pending on lane 2.
        rst = 1'b1;
        cyc(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
        cyc(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
        rst = 1'b0;
        cyc(1'b0, 2'd2, 32'h0, 4'b0000);

        // Single route to lane 1, then pop it.
        cyc(1'b1, 2'd1, 32'h12345678, 4'b0000);
        cyc(1'b0, 2'd1, 32'h0, 4'b0010);
        cyc(1'b0, 2'd1, 32'h0, 4'b0000);

        // Fill lane 0, observe irdy per select, hold the third word.
        cyc(1'b1, 2'd0, 32'hA0, 4'b0000);
        cyc(1'b1, 2'd0, 32'hA1, 4'b0000);
        cyc(1'b0, 2'd3, 32'h0, 4'b0000);
        for (int k = 0; k < 3; k++) cyc(1'b1, 2'd0, 32'hA2, 4'b0000);
        for (int k = 0; k < 4; k++) cyc(1'b1, 2'd0, 32'hA2, 4'b0001);
        cyc(1'b0, 2'd0, 32'h0, 4'b0001);
        cyc(1'b0, 2'd0, 32'h0, 4'b0001);

        // Lane 3 streaming with simultaneous push/pop across pointer wrap.
        cyc(1'b1, 2'd3, 32'hB0, 4'b0000);
        for (int k = 1; k <= 11; k++) cyc(1'b1, 2'd3, 32'hB0 + k, 4'b1000);
        cyc(1'b0, 2'd3, 32'h0, 4'b1000);
        cyc(1'b0, 2'd3, 32'h0, 4'b0000);

        // Independence: one word per lane, then drain only lane 2.
        for (int n = 0; n < 4; n++) cyc(1'b1, 2'(n), 32'hC0 + n, 4'b0000);
        cyc(1'b0, 2'd0, 32'h0, 4'b0100);
        cyc(1'b0, 2'd0, 32'h0, 4'b0100);
        cyc(1'b0, 2'd0, 32'h0, 4'b1011);
        cyc(1'b0, 2'd0, 32'h0, 4'b0000);

        // Reset mid-operation with a same-cycle push.
        cyc(1'b1, 2'd0, 32'hD0, 4'b0000);
        cyc(1'b1, 2'd2, 32'hD2, 4'b0000);
        rst = 1'b1;
        cyc(1'b1, 2'd0, 32'hD4, 4'b1111);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) cyc(1'b0, 2'd0, 32'h0, 4'b1111);

        // Random traffic; a refused word is held until accepted.
        iv = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            logic             niv;
            logic [1:0]       ns;
            logic [WIDTH-1:0] ni;
            if (iv && !last_acc) begin
                niv = iv;
                ns  = s;
                ni  = i;
            end else begin
                niv = ($urandom_range(0, 3) != 0);
                ns  = 2'($urandom_range(0, 3));
                ni  = $urandom;
            end
            cyc(niv, ns, ni, 4'($urandom));
        end
        for (int k = 0; k < 2 * DEPTH + 2; k++) cyc(1'b0, 2'd0, 32'h0, 4'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
